red_pitaya_iq_na_avg_block: RTL and testbench

Multi-channel network-analyzer averager, the parametrised successor of the single-pair I/Q sum logic inside the IQ block. It accumulates CHANNELS demodulated I/Q pairs over a programmable sleep-then-average window and latches the results into coherent snapshot registers. It supports single-shot and continuous modes, with a done pulse for the sweep controller. It sits between the IQ quadrature low-pass outputs and the PS bus.

---
 rtl/red_pitaya_iq_na_avg_block_if.sv | 27 ++
 rtl/red_pitaya_iq_na_avg_block.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_red_pitaya_iq_na_avg_block.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_iq_na_avg_block_if.sv
// Register bus of the network-analyzer averager: single-cycle strobes, registered response.
interface red_pitaya_iq_na_avg_block_if;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] wdata;

    modport master (
        output addr,
        output wen,
        output ren,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wen,
        input  ren,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/red_pitaya_iq_na_avg_block.sv
// Multi-channel network-analyzer I/Q averager.
// Accumulates CHANNELS demodulated I/Q pairs over a sleep-then-average window and latches the
// sums into snapshot registers readable over the register bus.
// Optional feature: define IQ_NA_SATURATE_EN to clamp accumulators instead of wrapping, with a
// sticky overflow flag in STATUS bit 4.
module red_pitaya_iq_na_avg_block #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned INBITS   = 24,
    parameter int unsigned SUMBITS  = 62,
    parameter int unsigned CNTBITS  = 32
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       trig_i,
    input  logic                       valid_i,
    input  logic [CHANNELS*INBITS-1:0] iq_i_i,
    input  logic [CHANNELS*INBITS-1:0] iq_q_i,
    output logic                       busy_o,
    output logic                       done_o,
    red_pitaya_iq_na_avg_block_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSleep   = 2'd1,
        StAverage = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Configuration registers
    logic               cont_q;
    logic [CNTBITS-1:0] avg_q;
    logic [CNTBITS-1:0] sleep_q;

    // Run counters
    logic [CNTBITS-1:0] sleep_rem_q;
    logic [CNTBITS-1:0] avg_rem_q;

    // Datapath
    logic signed [INBITS-1:0]  in_i [CHANNELS];
    logic signed [INBITS-1:0]  in_q [CHANNELS];
    logic signed [SUMBITS-1:0] acc_i_q [CHANNELS];
    logic signed [SUMBITS-1:0] acc_q_q [CHANNELS];
    logic signed [SUMBITS-1:0] acc_i_nxt [CHANNELS];
    logic signed [SUMBITS-1:0] acc_q_nxt [CHANNELS];
    logic signed [SUMBITS-1:0] snap_i_q [CHANNELS];
    logic signed [SUMBITS-1:0] snap_q_q [CHANNELS];
    logic [63:0]               snap_i_ext [CHANNELS];
    logic [63:0]               snap_q_ext [CHANNELS];
    logic                      snap_valid_q;
    logic [31:0]               runs_q;
    logic                      done_q;
    logic                      ovf;

    // Bus response
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Decoded events and datapath controls
    logic ctrl_wr;
    logic start;
    logic abort;
    logic load_run;
    logic latch;
    logic acc_en;
    logic sleep_dec;

    assign ctrl_wr = bus.wen && (bus.addr == 16'h0000);
    // trig_i and a bus start in the same cycle merge into a single start.
    assign start   = trig_i || (ctrl_wr && bus.wdata[0]);
    assign abort   = ctrl_wr && bus.wdata[1];

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; abort beats start, start beats the normal sequence
    always_comb begin
        state_e start_target;
        if (sleep_q != '0) begin
            start_target = StSleep;
        end else if (avg_q != '0) begin
            start_target = StAverage;
        end else begin
            start_target = StDone;
        end

        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else if (start) begin
            state_d = start_target;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StSleep: begin
                    if (sleep_rem_q == CNTBITS'(1)) begin
                        state_d = (avg_rem_q != '0) ? StAverage : StDone;
                    end
                end
                StAverage: begin
                    if (valid_i && (avg_rem_q == CNTBITS'(1))) begin
                        state_d = StDone;
                    end
                end
                StDone: state_d = cont_q ? start_target : StIdle;
            endcase
        end
    end

    // FSM outputs: datapath controls and busy
    always_comb begin
        busy_o    = (state_q == StSleep) || (state_q == StAverage);
        load_run  = !abort && (start || ((state_q == StDone) && cont_q));
        latch     = !abort && (state_q == StDone);
        acc_en    = !abort && !start && (state_q == StAverage) && valid_i;
        sleep_dec = !abort && !start && (state_q == StSleep);
    end

    // Unpack the channel inputs, channel 0 in the LSBs
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            in_i[c] = iq_i_i[c*INBITS +: INBITS];
            in_q[c] = iq_q_i[c*INBITS +: INBITS];
        end
    end

`ifdef IQ_NA_SATURATE_EN
    logic clamp_any;
    logic ovf_q;

    // Returns {clamped, sum}; the sum is pinned to the signed limit on overflow.
    function automatic logic [SUMBITS:0] sat_add(input logic signed [SUMBITS-1:0] acc,
                                                 input logic signed [INBITS-1:0]  x);
        logic signed [SUMBITS:0] wide;
        wide = (SUMBITS+1)'(acc) + (SUMBITS+1)'(x);
        if (wide[SUMBITS] != wide[SUMBITS-1]) begin
            sat_add = {1'b1, wide[SUMBITS], {(SUMBITS-1){~wide[SUMBITS]}}};
        end else begin
            sat_add = {1'b0, wide[SUMBITS-1:0]};
        end
    endfunction

    // Saturating accumulator update
    always_comb begin
        logic ci;
        logic cq;
        clamp_any = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            ci = 1'b0;
            cq = 1'b0;
            {ci, acc_i_nxt[c]} = sat_add(acc_i_q[c], in_i[c]);
            {cq, acc_q_nxt[c]} = sat_add(acc_q_q[c], in_q[c]);
            clamp_any = clamp_any || ci || cq;
        end
    end

    // Sticky overflow, cleared when a new run is loaded
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= 1'b0;
        end else if (load_run) begin
            ovf_q <= 1'b0;
        end else if (acc_en && clamp_any) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    // Wrapping accumulator update
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            acc_i_nxt[c] = acc_i_q[c] + SUMBITS'(in_i[c]);
            acc_q_nxt[c] = acc_q_q[c] + SUMBITS'(in_q[c]);
        end
    end

    assign ovf = 1'b0;
`endif

    // Accumulators: cleared at run load, summed on qualified samples
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_i_q[c] <= '0;
                acc_q_q[c] <= '0;
            end
        end else if (load_run) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_i_q[c] <= '0;
                acc_q_q[c] <= '0;
            end
        end else if (acc_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_i_q[c] <= acc_i_nxt[c];
                acc_q_q[c] <= acc_q_nxt[c];
            end
        end
    end

    // Sleep and average countdowns
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sleep_rem_q <= '0;
            avg_rem_q   <= '0;
        end else if (load_run) begin
            sleep_rem_q <= sleep_q;
            avg_rem_q   <= avg_q;
        end else if (sleep_dec) begin
            sleep_rem_q <= sleep_rem_q - CNTBITS'(1);
        end else if (acc_en) begin
            avg_rem_q <= avg_rem_q - CNTBITS'(1);
        end
    end

    // Snapshots are copied as a whole on leaving DONE, so readers never see a torn update
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                snap_i_q[c] <= '0;
                snap_q_q[c] <= '0;
            end
            snap_valid_q <= 1'b0;
            runs_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= latch;
            if (latch) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    snap_i_q[c] <= acc_i_q[c];
                    snap_q_q[c] <= acc_q_q[c];
                end
                snap_valid_q <= 1'b1;
                runs_q       <= runs_q + 32'd1;
            end
        end
    end

    assign done_o = done_q;

    // Configuration register writes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cont_q  <= 1'b0;
            avg_q   <= '0;
            sleep_q <= '0;
        end else if (bus.wen) begin
            case (bus.addr)
                16'h0000: cont_q  <= bus.wdata[2];
                16'h0004: avg_q   <= CNTBITS'(bus.wdata);
                16'h0008: sleep_q <= CNTBITS'(bus.wdata);
                default: ;
            endcase
        end
    end

    // Sign-extend snapshots to 64 bits for the low/high word split
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            snap_i_ext[c] = 64'(snap_i_q[c]);
            snap_q_ext[c] = 64'(snap_q_q[c]);
        end
    end

    // Read-data decode
    always_comb begin
        rdata_d = '0;
        case (bus.addr)
            16'h0000: rdata_d = {29'b0, cont_q, 2'b0};
            16'h0004: rdata_d = 32'(avg_q);
            16'h0008: rdata_d = 32'(sleep_q);
            16'h000C: rdata_d = {27'b0, ovf, runs_q[0], snap_valid_q, state_q};
            16'h0010: rdata_d = runs_q;
            default: ;
        endcase
        for (int c = 0; c < CHANNELS; c++) begin
            if ((bus.addr[15:8] == 8'h01) && (bus.addr[7:4] == 4'(c)) &&
                (bus.addr[1:0] == 2'b00)) begin
                case (bus.addr[3:2])
                    2'd0: rdata_d = snap_i_ext[c][31:0];
                    2'd1: rdata_d = snap_i_ext[c][63:32];
                    2'd2: rdata_d = snap_q_ext[c][31:0];
                    default: rdata_d = snap_q_ext[c][63:32];
                endcase
            end
        end
    end

    // Registered bus response; every strobe is acknowledged, mapped or not
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= bus.wen || bus.ren;
            if (bus.ren) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_red_pitaya_iq_na_avg_block.sv
// Directed bench for red_pitaya_iq_na_avg_block: vector table plus corner-case sequences.
module tb_red_pitaya_iq_na_avg_block;
    localparam int unsigned CH = 2;
    localparam int unsigned IB = 24;

    logic             clk = 1'b0;
    logic             rstn;
    logic             trig;
    logic             valid;
    logic [CH*IB-1:0] iq_i;
    logic [CH*IB-1:0] iq_q;
    logic             busy;
    logic             done;
    logic             trig33;
    logic             valid33;
    logic [IB-1:0]    iq_i33;
    logic [IB-1:0]    iq_q33;
    logic             busy33;
    logic             done33;

    int checks   = 0;
    int failures = 0;

    red_pitaya_iq_na_avg_block_if bus ();
    red_pitaya_iq_na_avg_block_if bus33 ();

    red_pitaya_iq_na_avg_block #(
        .CHANNELS(CH),
        .INBITS  (IB),
        .SUMBITS (62),
        .CNTBITS (32)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .trig_i (trig),
        .valid_i(valid),
        .iq_i_i (iq_i),
        .iq_q_i (iq_q),
        .busy_o (busy),
        .done_o (done),
        .bus    (bus.slave)
    );

    red_pitaya_iq_na_avg_block #(
        .CHANNELS(1),
        .INBITS  (IB),
        .SUMBITS (33),
        .CNTBITS (32)
    ) dut33 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .trig_i (trig33),
        .valid_i(valid33),
        .iq_i_i (iq_i33),
        .iq_q_i (iq_q33),
        .busy_o (busy33),
        .done_o (done33),
        .bus    (bus33.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                sleep;
        int                avgs;
        bit                tog;
        bit                use_bus;
        logic signed [23:0] i0;
        logic signed [23:0] q0;
        logic signed [23:0] i1;
        logic signed [23:0] q1;
        int                lat;
        longint            e_i0;
        longint            e_q0;
        longint            e_i1;
        longint            e_q1;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wen   = 1'b1;
        tick();
        bus.wen   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
        bus.addr = a;
        bus.ren  = 1'b1;
        tick();
        bus.ren  = 1'b0;
        check({name, "_ack"}, 64'(bus.ack), 64'd1);
        check(name, 64'(bus.rdata), 64'(exp));
    endtask

    task automatic wr33(input logic [15:0] a, input logic [31:0] d);
        bus33.addr  = a;
        bus33.wdata = d;
        bus33.wen   = 1'b1;
        tick();
        bus33.wen   = 1'b0;
    endtask

    task automatic rd33_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
        bus33.addr = a;
        bus33.ren  = 1'b1;
        tick();
        bus33.ren  = 1'b0;
        check(name, 64'(bus33.rdata), 64'(exp));
    endtask

    // Drives valid per cycle and returns the number of edges from the start edge to done_o.
    task automatic run_to_done(input int s, input bit tog, input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            valid = tog ? (((k + s) % 2) == 1) : 1'b1;
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          seen;
        logic [63:0] ex [4];
        logic [63:0] e;
        logic [15:0] a;

        rstn = 1'b0;
        trig = 1'b0; valid = 1'b0; iq_i = '0; iq_q = '0;
        trig33 = 1'b0; valid33 = 1'b0; iq_i33 = '0; iq_q33 = '0;
        bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.ren = 1'b0;
        bus33.addr = '0; bus33.wdata = '0; bus33.wen = 1'b0; bus33.ren = 1'b0;

        vecs[0] = '{3, 4, 1'b0, 1'b0, 24'sd100, 24'sd0, 24'sd0, -24'sd7,
                    8, 400, 0, 0, -28};
        vecs[1] = '{2, 4, 1'b1, 1'b1, -24'sd5, 24'sd3, 24'sd1000, 24'sd0,
                    10, -20, 12, 4000, 0};
        vecs[2] = '{0, 0, 1'b0, 1'b0, 24'sd55, 24'sd66, 24'sd77, 24'sd88,
                    1, 0, 0, 0, 0};
        vecs[3] = '{0, 1, 1'b0, 1'b1, 24'sd8388607, -24'sd8388608, -24'sd1, 24'sd1,
                    2, 8388607, -8388608, -1, 1};
        vecs[4] = '{5, 0, 1'b0, 1'b0, 24'sd9, 24'sd9, 24'sd9, 24'sd9,
                    6, 0, 0, 0, 0};
        vecs[5] = '{1, 3, 1'b0, 1'b1, -24'sd8388608, 24'sd8388607, 24'sd12345, -24'sd1,
                    5, -25165824, 25165821, 37035, -3};

        // Reset state
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        rstn = 1'b1;
        tick();
        rd_chk("rst_ctrl", 16'h0000, 32'h0);
        rd_chk("rst_status", 16'h000C, 32'h0);
        rd_chk("rst_runs", 16'h0010, 32'h0);
        rd_chk("rst_snap", 16'h0100, 32'h0);

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            bus_wr(16'h0008, 32'(vecs[v].sleep));
            bus_wr(16'h0004, 32'(vecs[v].avgs));
            rd_chk("avg_rb", 16'h0004, 32'(vecs[v].avgs));
            rd_chk("sleep_rb", 16'h0008, 32'(vecs[v].sleep));
            iq_i  = {vecs[v].i1, vecs[v].i0};
            iq_q  = {vecs[v].q1, vecs[v].q0};
            valid = 1'b1;
            if (vecs[v].use_bus) begin
                bus.addr  = 16'h0000;
                bus.wdata = 32'h1;
                bus.wen   = 1'b1;
            end else begin
                trig = 1'b1;
            end
            tick();
            bus.wen = 1'b0;
            trig    = 1'b0;
            check("busy_start", 64'(busy), 64'((vecs[v].sleep != 0) || (vecs[v].avgs != 0)));
            run_to_done(vecs[v].sleep, vecs[v].tog, 100, lat);
            check("done_latency", 64'(lat), 64'(vecs[v].lat));
            tick();
            check("done_pulse_width", 64'(done), 64'd0);
            check("idle_after_run", 64'(busy), 64'd0);
            ex[0] = 64'(vecs[v].e_i0);
            ex[1] = 64'(vecs[v].e_q0);
            ex[2] = 64'(vecs[v].e_i1);
            ex[3] = 64'(vecs[v].e_q1);
            for (int c = 0; c < 2; c++) begin
                for (int w = 0; w < 2; w++) begin
                    a = 16'h0100 + 16'(16 * c + 8 * w);
                    e = ex[2*c + w];
                    rd_chk("snap_lo", a, e[31:0]);
                    rd_chk("snap_hi", a + 16'h4, e[63:32]);
                end
            end
            rd_chk("runs", 16'h0010, 32'(v + 1));
            rd_chk("status", 16'h000C, 32'h4 | (32'((v + 1) & 1) << 3));
        end

        // Unmapped addresses read zero
        rd_chk("unmapped_20", 16'h0020, 32'h0);
        rd_chk("unmapped_ch2", 16'h0120, 32'h0);

        // Continuous mode, SLEEP=0 AVERAGES=2: done every 3 cycles, then abort mid-run
        bus_wr(16'h0008, 32'd0);
        bus_wr(16'h0004, 32'd2);
        bus_wr(16'h0000, 32'h4);
        rd_chk("ctrl_cont_rb", 16'h0000, 32'h4);
        iq_i = {24'sd0, 24'sd10};
        iq_q = '0;
        valid = 1'b1;
        bus_wr(16'h0000, 32'h5);
        run_to_done(0, 1'b0, 20, lat);
        check("cont_lat0", 64'(lat), 64'd3);
        run_to_done(0, 1'b0, 20, lat);
        check("cont_period1", 64'(lat), 64'd3);
        run_to_done(0, 1'b0, 20, lat);
        check("cont_period2", 64'(lat), 64'd3);
        iq_i = {24'sd0, 24'sd99};
        valid = 1'b1;
        tick();
        bus_wr(16'h0000, 32'h2);
        valid = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        rd_chk("abort_status", 16'h000C, 32'h0000000C);
        rd_chk("abort_runs", 16'h0010, 32'd9);
        rd_chk("abort_snap_keep", 16'h0100, 32'd20);
        rd_chk("abort_ctrl", 16'h0000, 32'h0);

        // Start and abort in the same cycle, with trig_i also high
        trig = 1'b1;
        bus_wr(16'h0000, 32'h3);
        trig = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        rd_chk("start_abort_status", 16'h000C, 32'h0000000C);

        // Asynchronous reset in AVERAGE
        bus_wr(16'h0004, 32'd10);
        valid = 1'b1;
        trig  = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        check("avg_busy", 64'(busy), 64'd1);
        rd_chk("runs_before_rst", 16'h0010, 32'd9);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_ack", 64'(bus.ack), 64'd0);
        check("mid_rst_rdata", 64'(bus.rdata), 64'd0);
        valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        rd_chk("post_rst_runs", 16'h0010, 32'd0);
        rd_chk("post_rst_snap", 16'h0100, 32'd0);
        rd_chk("post_rst_avg", 16'h0004, 32'd0);

        // 33-bit accumulator with 1100 full-scale samples
        wr33(16'h0004, 32'd1100);
        iq_i33  = 24'h7FFFFF;
        iq_q33  = '0;
        valid33 = 1'b1;
        trig33  = 1'b1;
        tick();
        trig33 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 1200; k++) begin
            tick();
            if (done33) begin
                lat = k;
                break;
            end
        end
        valid33 = 1'b0;
        check("sb33_latency", 64'(lat), 64'd1101);
`ifdef IQ_NA_SATURATE_EN
        rd33_chk("sb33_i_lo", 16'h0100, 32'hFFFFFFFF);
        rd33_chk("sb33_i_hi", 16'h0104, 32'h0);
        rd33_chk("sb33_status", 16'h000C, 32'h0000001C);
`else
        rd33_chk("sb33_i_lo", 16'h0100, 32'h25FFFBB4);
        rd33_chk("sb33_i_hi", 16'h0104, 32'h0);
        rd33_chk("sb33_status", 16'h000C, 32'h0000000C);
`endif
        rd33_chk("sb33_q_lo", 16'h0108, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
